// File: rtl/apb2axi_rd_engine.sv
// apb2axi_rd_engine
// -----------------
// AXI read-issue engine for the APB-to-AXI bridge. It takes one read
// descriptor from the request FIFO, issues a single INCR burst on AR, and
// forwards every R beat into the response FIFO. Only one burst is in flight
// at a time.
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   req_pop_*        consumer side of the request FIFO; data = {len, addr}
//   ar*              AXI read address channel (ARID, ARSIZE, ARBURST constant)
//   r*               AXI read data channel
//   rsp_push_*       producer side of the response FIFO;
//                    data = {exp_last, rresp, rdata}
//   busy             engine is not idle
//   err_id/last/resp sticky error flags, cleared by an err_clr pulse
module apb2axi_rd_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_pop_valid,
  output logic                req_pop_ready,
  input  logic [ADDR_W+7:0]   req_pop_data,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [ID_W-1:0]     arid,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic [ID_W-1:0]     rid,
  output logic                rsp_push_valid,
  input  logic                rsp_push_ready,
  output logic [DATA_W+2:0]   rsp_push_data,
  output logic                busy,
  output logic                err_id,
  output logic                err_last,
  output logic                err_resp,
  input  logic                err_clr
);

  localparam logic [ID_W-1:0] ARID_C   = ID_W'(AXI_ID);
  localparam logic [2:0]      ARSIZE_C = 3'($clog2(DATA_W / 8));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [7:0]          len_reg, len_next;
  logic [7:0]          beat_cnt_reg, beat_cnt_next;
  logic [2:0]          err_reg, err_next;
  logic [2:0]          err_set;
  logic                beat_accept;
  logic                exp_last;

  // Burst termination relies only on the beat count; RLAST is merely checked.
  assign exp_last = (beat_cnt_reg == len_reg);

  assign arid          = ARID_C;
  assign arsize        = ARSIZE_C;
  assign arburst       = 2'b01;
  assign araddr        = addr_reg;
  assign arlen         = len_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign rsp_push_data = {exp_last, rresp, rdata};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
      err_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    len_next       = len_reg;
    beat_cnt_next  = beat_cnt_reg;
    req_pop_ready  = 1'b0;
    arvalid        = 1'b0;
    rready         = 1'b0;
    rsp_push_valid = 1'b0;
    beat_accept    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_pop_ready = 1'b1;
        if (req_pop_valid) begin
          addr_next     = req_pop_data[ADDR_W-1:0];
          len_next      = req_pop_data[ADDR_W+7:ADDR_W];
          beat_cnt_next = '0;
          state_next    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_next = ST_DATA;
      end
      ST_DATA: begin
        // R ready follows FIFO space; push valid follows rvalid alone so the
        // FIFO side never sees a valid that waits on its own ready.
        rready         = rsp_push_ready;
        rsp_push_valid = rvalid;
        beat_accept    = rvalid && rsp_push_ready;
        if (beat_accept) begin
          beat_cnt_next = beat_cnt_reg + 8'd1;
          if (exp_last) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // err bit order: [2] id, [1] last, [0] resp
  assign err_set[2] = beat_accept && (rid != ARID_C);
  assign err_set[1] = beat_accept && (rlast != exp_last);
  assign err_set[0] = beat_accept && (rresp != 2'b00);

  // A new error in the same cycle as err_clr keeps the flag set.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_err
      assign err_next[gi] = err_set[gi] | (err_reg[gi] & ~err_clr);
    end
  endgenerate

  assign err_id   = err_reg[2];
  assign err_last = err_reg[1];
  assign err_resp = err_reg[0];

endmodule

// File: tb/tb_apb2axi_rd_engine.sv
// Directed testbench for apb2axi_rd_engine (default parameters).
module tb_apb2axi_rd_engine;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_pop_valid;
  logic        req_pop_ready;
  logic [39:0] req_pop_data;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [3:0]  arid;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;
  logic        rsp_push_valid;
  logic        rsp_push_ready;
  logic [66:0] rsp_push_data;
  logic        busy;
  logic        err_id;
  logic        err_last;
  logic        err_resp;
  logic        err_clr;

  int checks = 0;
  int errors = 0;
  logic [66:0] push_q[$];
  logic par = 1'b0;

  apb2axi_rd_engine dut (
    .clk(clk), .resetn(resetn),
    .req_pop_valid(req_pop_valid), .req_pop_ready(req_pop_ready), .req_pop_data(req_pop_data),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arid(arid), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .rsp_push_valid(rsp_push_valid), .rsp_push_ready(rsp_push_ready), .rsp_push_data(rsp_push_data),
    .busy(busy), .err_id(err_id), .err_last(err_last), .err_resp(err_resp), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Record every response FIFO write mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (resetn && rsp_push_valid && rsp_push_ready) push_q.push_back(rsp_push_data);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pop(input logic [31:0] a, input logic [7:0] l);
    req_pop_valid = 1'b1;
    req_pop_data  = {l, a};
    tick();
    req_pop_valid = 1'b0;
  endtask

  task automatic do_ar(input int delay);
    logic done;
    arready = 1'b0;
    repeat (delay) tick();
    arready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      done = arvalid;
      tick();
    end
    arready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL ar_handshake_timeout got arvalid=%0b exp 1", arvalid);
    end
  endtask

  task automatic r_beats(input int n, input logic [63:0] base, input int last_pos,
                         input logic [3:0] rid_v, input int bad_idx, input logic toggle);
    logic got;
    for (int i = 0; i < n; i++) begin
      rvalid = 1'b1;
      rdata  = base + 64'(i);
      rlast  = (i == last_pos);
      rid    = rid_v;
      rresp  = (i == bad_idx) ? 2'b10 : 2'b00;
      got    = 1'b0;
      for (int c = 0; c < 64 && !got; c++) begin
        if (toggle) begin
          par = ~par;
          rsp_push_ready = par;
        end else begin
          rsp_push_ready = 1'b1;
        end
        #1;
        got = rready;
        @(posedge clk);
        #1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL r_beat_timeout beat %0d got rready=0 exp 1", i);
      end
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    rid    = 4'd0;
    rsp_push_ready = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    rvalid = 1'b1;
    rsp_push_ready = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
    #1;
    checks++; if (req_pop_ready !== 1'b1) begin errors++; $display("FAIL rst_req_pop_ready got %b exp 1", req_pop_ready); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid got %b exp 0", arvalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL rst_rready got %b exp 0", rready); end
    checks++; if (rsp_push_valid !== 1'b0) begin errors++; $display("FAIL rst_push_valid got %b exp 0", rsp_push_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if ({err_id, err_last, err_resp} !== 3'b000) begin errors++; $display("FAIL rst_err got %b exp 000", {err_id, err_last, err_resp}); end
    checks++; if (araddr !== 32'h0 || arlen !== 8'h0) begin errors++; $display("FAIL rst_ar got %h/%h exp 0/0", araddr, arlen); end
    rvalid = 1'b0;
    tick();
  endtask

  task automatic test_single;
    push_q.delete();
    pop(32'h1000, 8'd0);
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h1000 || arlen !== 8'd0) begin errors++; $display("FAIL single_ar got %b %h %h exp 1 00001000 00", arvalid, araddr, arlen); end
    checks++; if ({arid, arsize, arburst} !== {4'd0, 3'd3, 2'b01}) begin errors++; $display("FAIL single_ar_const got %h %h %h exp 0 3 1", arid, arsize, arburst); end
    checks++; if (req_pop_ready !== 1'b0) begin errors++; $display("FAIL single_pop_ready got %b exp 0", req_pop_ready); end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    checks++; if (busy !== 1'b1 || arvalid !== 1'b0) begin errors++; $display("FAIL single_data_state got busy=%b arvalid=%b exp 1 0", busy, arvalid); end
    rvalid = 1'b1; rdata = 64'h55; rlast = 1'b1; rid = 4'd0; rresp = 2'b00; rsp_push_ready = 1'b1;
    #1;
    checks++; if (rsp_push_valid !== 1'b1 || rsp_push_data !== {1'b1, 2'b00, 64'h55}) begin errors++; $display("FAIL single_push got %b %h exp 1 %h", rsp_push_valid, rsp_push_data, {1'b1, 2'b00, 64'h55}); end
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_3cyc got %b exp 0", busy); end
    checks++; if (push_q.size() != 1) begin errors++; $display("FAIL single_push_count got %0d exp 1", push_q.size()); end
  endtask

  task automatic test_burst4;
    logic [66:0] e;
    push_q.delete();
    pop(32'h2000, 8'd3);
    do_ar(0);
    r_beats(4, 64'hA0, 3, 4'd0, -1, 1'b0);
    checks++; if (push_q.size() != 4) begin errors++; $display("FAIL b4_count got %0d exp 4", push_q.size()); end
    for (int i = 0; i < 4 && i < push_q.size(); i++) begin
      e = {(i == 3), 2'b00, 64'hA0 + 64'(i)};
      checks++; if (push_q[i] !== e) begin errors++; $display("FAIL b4_beat%0d got %h exp %h", i, push_q[i], e); end
    end
    checks++; if ({err_id, err_last, err_resp} !== 3'b000) begin errors++; $display("FAIL b4_err got %b exp 000", {err_id, err_last, err_resp}); end
    // back-to-back: next descriptor popped in the cycle right after the last beat
    checks++; if (req_pop_ready !== 1'b1) begin errors++; $display("FAIL b2b_pop_ready got %b exp 1", req_pop_ready); end
    pop(32'h2100, 8'd0);
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h2100) begin errors++; $display("FAIL b2b_ar got %b %h exp 1 00002100", arvalid, araddr); end
    do_ar(0);
    r_beats(1, 64'hB0, 0, 4'd0, -1, 1'b0);
    checks++; if (push_q.size() != 5 || push_q[push_q.size()-1] !== {1'b1, 2'b00, 64'hB0}) begin errors++; $display("FAIL b2b_push got n=%0d exp 5", push_q.size()); end
  endtask

  task automatic test_stall;
    push_q.delete();
    pop(32'h3000, 8'd7);
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h3000 || arlen !== 8'd7) begin
        errors++; $display("FAIL stall_ar_stable cyc %0d got %b %h %h exp 1 00003000 07", d, arvalid, araddr, arlen);
      end
      tick();
    end
    do_ar(0);
    r_beats(8, 64'hC0, 7, 4'd0, -1, 1'b1);
    checks++; if (push_q.size() != 8) begin errors++; $display("FAIL stall_count got %0d exp 8", push_q.size()); end
    for (int i = 0; i < 8 && i < push_q.size(); i++) begin
      checks++;
      if (push_q[i] !== {(i == 7), 2'b00, 64'hC0 + 64'(i)}) begin
        errors++; $display("FAIL stall_beat%0d got %h exp %h", i, push_q[i], {(i == 7), 2'b00, 64'hC0 + 64'(i)});
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle got %b exp 0", busy); end
  endtask

  task automatic test_errors;
    push_q.delete();
    pop(32'h4000, 8'd3);
    do_ar(0);
    r_beats(4, 64'hD0, 1, 4'd5, -1, 1'b0);
    checks++; if (push_q.size() != 4) begin errors++; $display("FAIL err_count got %0d exp 4", push_q.size()); end
    checks++; if (push_q.size() == 4 && {push_q[0][66], push_q[1][66], push_q[2][66], push_q[3][66]} !== 4'b0001) begin errors++; $display("FAIL err_explast got %b exp 0001", {push_q[0][66], push_q[1][66], push_q[2][66], push_q[3][66]}); end
    checks++; if ({err_id, err_last, err_resp} !== 3'b110) begin errors++; $display("FAIL err_flags got %b exp 110", {err_id, err_last, err_resp}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_idle got %b exp 0", busy); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if ({err_id, err_last, err_resp} !== 3'b000) begin errors++; $display("FAIL err_clr got %b exp 000", {err_id, err_last, err_resp}); end
  endtask

  task automatic test_resp;
    push_q.delete();
    pop(32'h5000, 8'd3);
    do_ar(0);
    r_beats(4, 64'hE0, 3, 4'd0, 2, 1'b0);
    checks++; if ({err_id, err_last, err_resp} !== 3'b001) begin errors++; $display("FAIL resp_flags got %b exp 001", {err_id, err_last, err_resp}); end
    checks++; if (push_q.size() != 4 || push_q[2] !== {1'b0, 2'b10, 64'hE2}) begin errors++; $display("FAIL resp_beat2 got n=%0d exp 4 with resp 10", push_q.size()); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid;
    push_q.delete();
    pop(32'h6000, 8'd7);
    do_ar(0);
    r_beats(2, 64'hF0, -1, 4'd0, -1, 1'b0);
    rvalid = 1'b1; rdata = 64'hF2;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || req_pop_ready !== 1'b1 || arvalid !== 1'b0) begin errors++; $display("FAIL midrst_state got busy=%b pop=%b arvalid=%b exp 0 1 0", busy, req_pop_ready, arvalid); end
    checks++; if (rready !== 1'b0 || rsp_push_valid !== 1'b0) begin errors++; $display("FAIL midrst_r got rready=%b pv=%b exp 0 0", rready, rsp_push_valid); end
    checks++; if (araddr !== 32'h0 || arlen !== 8'h0) begin errors++; $display("FAIL midrst_ar got %h/%h exp 0/0", araddr, arlen); end
    rvalid = 1'b0;
    push_q.delete();
    pop(32'h7000, 8'd0);
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h7000 || arlen !== 8'd0) begin errors++; $display("FAIL midrst_new_ar got %b %h %h exp 1 00007000 00", arvalid, araddr, arlen); end
    do_ar(0);
    r_beats(1, 64'h77, 0, 4'd0, -1, 1'b0);
    checks++; if (push_q.size() != 1 || push_q[0] !== {1'b1, 2'b00, 64'h77}) begin errors++; $display("FAIL midrst_new_push got n=%0d exp 1", push_q.size()); end
    checks++; if ({err_id, err_last, err_resp} !== 3'b000) begin errors++; $display("FAIL midrst_err got %b exp 000", {err_id, err_last, err_resp}); end
  endtask

  initial begin
    resetn = 1'b0; req_pop_valid = 1'b0; req_pop_data = '0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = 4'd0;
    rsp_push_ready = 1'b1; err_clr = 1'b0;
    tick();
    test_reset();
    test_single();
    test_burst4();
    test_stall();
    test_errors();
    test_resp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
